emif_async_frontend: RTL and testbench

EMIF_ASYNC_FRONTEND -- requirements
Module: emif_async_frontend

---
 rtl/emif_async_frontend.sv | 196 +++++++++++++++++++
 tb/tb_emif_async_frontend.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_async_frontend.sv
// Asynchronous EMIF slave front end: synchronizes and deglitches the strobes,
// then turns bus cycles into single-cycle register write/read requests.
module emif_async_frontend #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  emif_ce_n,
    input  logic                  emif_we_n,
    input  logic                  emif_oe_n,
    input  logic [ADDR_WIDTH-1:0] emif_addr,
    input  logic [DATA_WIDTH-1:0] emif_data_in,
    output logic [DATA_WIDTH-1:0] emif_data_out,
    output logic                  emif_data_oe,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    output logic                  rd_timeout
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [FCW-1:0] FMAX = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMAX = TCW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DRIVE} state_t;

    // Strobe index: 0 = ce_n, 1 = we_n, 2 = oe_n
    logic [2:0]             strb_pin;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             strb_s;
    logic [2:0]             filt_q, filt_d;
    logic [FCW-1:0]         fcnt_q [3];
    logic [FCW-1:0]         fcnt_d [3];

    logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] addr_sync_q;
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] data_sync_q;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  doe_q, doe_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_to_q, rd_to_d;
    logic                  ce_act, we_act, oe_act;

    assign strb_pin = {emif_oe_n, emif_we_n, emif_ce_n};
    assign addr_s   = addr_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];

    // A filter output flips only once FILTER_LEN consecutive samples disagree with it
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            strb_s[i] = sync_q[i][SYNC_STAGES-1];
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (strb_s[i] != filt_q[i]) begin
                if (fcnt_q[i] == FMAX) filt_d[i] = strb_s[i];
                else                   fcnt_d[i] = fcnt_q[i] + FCW'(1);
            end
        end
    end

    assign ce_act = ~filt_q[0];
    assign we_act = ~filt_q[1];
    assign oe_act = ~filt_q[2];

    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        tcnt_d      = tcnt_q;
        dout_d      = dout_q;
        doe_d       = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_to_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ce_act && we_act) begin
                    state_d = WRITE;
                end else if (ce_act && oe_act) begin
                    state_d   = READ_WAIT;
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_s;
                    tcnt_d    = '0;
                end
            end
            WRITE: begin
                if (ce_act && we_act) begin
                    hold_addr_d = addr_s;
                    hold_data_d = data_s;
                end else begin
                    state_d   = IDLE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = hold_addr_q;
                    wr_data_d = hold_data_q;
                end
            end
            READ_WAIT: begin
                if (!(ce_act && oe_act)) begin
                    state_d = IDLE;
                end else if (rd_valid) begin
                    state_d = READ_DRIVE;
                    dout_d  = rd_data;
                    doe_d   = 1'b1;
                end else if (tcnt_q == TMAX) begin
                    state_d = READ_DRIVE;
                    dout_d  = '1;
                    doe_d   = 1'b1;
                    rd_to_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            READ_DRIVE: begin
                if (ce_act && oe_act) doe_d = 1'b1;
                else                  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                sync_q[i] <= '1;
                fcnt_q[i] <= '0;
            end
            filt_q      <= '1;
            addr_sync_q <= '0;
            data_sync_q <= '0;
            state_q     <= IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            tcnt_q      <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_to_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], strb_pin[i]};
                fcnt_q[i] <= fcnt_d[i];
            end
            filt_q      <= filt_d;
            addr_sync_q <= {addr_sync_q[SYNC_STAGES-2:0], emif_addr};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], emif_data_in};
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            tcnt_q      <= tcnt_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            rd_to_q     <= rd_to_d;
        end
    end

    assign emif_data_out = dout_q;
    assign emif_data_oe  = doe_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;
    assign rd_timeout    = rd_to_q;

endmodule

// File: tb/tb_emif_async_frontend.sv
// Bench for emif_async_frontend: directed vector table, reset corner cases and
// randomized bus cycles checked against an event-timing reference model.
module tb_emif_async_frontend;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int SS  = 2;
    localparam int FL  = 2;
    localparam int RT  = 15;
    localparam int LAT = SS + FL;
    localparam int BIG = 1 << 30;

    localparam int EV_WR  = 0;
    localparam int EV_RQ  = 1;
    localparam int EV_TO  = 2;
    localparam int EV_DRV = 3;
    localparam int EV_REL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          emif_ce_n, emif_we_n, emif_oe_n;
    logic [AW-1:0] emif_addr;
    logic [DW-1:0] emif_data_in;
    logic [DW-1:0] emif_data_out;
    logic          emif_data_oe;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_timeout;

    emif_async_frontend #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SYNC_STAGES(SS),
        .FILTER_LEN (FL),
        .RD_TIMEOUT (RT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .emif_ce_n    (emif_ce_n),
        .emif_we_n    (emif_we_n),
        .emif_oe_n    (emif_oe_n),
        .emif_addr    (emif_addr),
        .emif_data_in (emif_data_in),
        .emif_data_out(emif_data_out),
        .emif_data_oe (emif_data_oe),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_timeout   (rd_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            len;
        int            vd;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct {
        txn_t        t;
        int          n_wr, n_rq, n_to, n_drv;
        int          key_off;
        logic [31:0] key_a, key_b;
        int          rel_off;
    } vec_t;

    ev_t act[$];
    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    function automatic ev_t mke(input int kind, input int c, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.b = b;
        return e;
    endfunction

    function automatic txn_t mkt(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int len, input int vd, input logic [DW-1:0] rdat);
        txn_t t;
        t.is_rd = rd; t.addr = a; t.data = d; t.len = len; t.vd = vd; t.rdata = rdat;
        return t;
    endfunction

    function automatic vec_t mkv(input txn_t t, input int nwr, input int nrq, input int nto, input int ndrv,
                                 input int koff, input logic [31:0] ka, input logic [31:0] kb, input int roff);
        vec_t v;
        v.t = t; v.n_wr = nwr; v.n_rq = nrq; v.n_to = nto; v.n_drv = ndrv;
        v.key_off = koff; v.key_a = ka; v.key_b = kb; v.rel_off = roff;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    logic doe_prev = 1'b0;
    always @(negedge clk) begin
        if (wr_en)      act.push_back(mke(EV_WR, cyc, 32'(wr_addr), 32'(wr_data)));
        if (rd_req)     act.push_back(mke(EV_RQ, cyc, 32'(rd_addr), 32'd0));
        if (rd_timeout) act.push_back(mke(EV_TO, cyc, 32'd0, 32'd0));
        if (emif_data_oe && !doe_prev) act.push_back(mke(EV_DRV, cyc, 32'(emif_data_out), 32'd0));
        if (!emif_data_oe && doe_prev) act.push_back(mke(EV_REL, cyc, 32'd0, 32'd0));
        doe_prev = emif_data_oe;
    end

    // Reference: a pin edge after clock k is seen by the FSM at edge k+LAT+1.
    function automatic void predict(input txn_t t, input int k);
        int r, jv, jd;
        logic [DW-1:0] ones;
        ones = '1;
        if (t.len < FL) return;
        if (!t.is_rd) begin
            expq.push_back(mke(EV_WR, k + t.len + LAT + 1, 32'(t.addr), 32'(t.data)));
            return;
        end
        r  = k + LAT + 1;
        expq.push_back(mke(EV_RQ, r, 32'(t.addr), 32'd0));
        jv = (t.vd >= 0) ? t.vd + 1 : BIG;
        jd = (jv < RT) ? jv : RT;
        if (t.len <= jd) return;
        if (RT < jv) expq.push_back(mke(EV_TO, r + RT, 32'd0, 32'd0));
        expq.push_back(mke(EV_DRV, r + jd, (jv <= RT) ? 32'(t.rdata) : 32'(ones), 32'd0));
        expq.push_back(mke(EV_REL, r + t.len, 32'd0, 32'd0));
    endfunction

    // Entered just after a rising edge; strobes go low for t.len clocks.
    task automatic run_txn(input txn_t t);
        int vcyc, total;
        vcyc  = (t.is_rd && t.vd >= 0) ? LAT + 1 + t.vd : -1;
        total = ((t.len > vcyc + 1) ? t.len : vcyc + 1) + LAT + 6;
        emif_addr    = t.addr;
        emif_data_in = t.data;
        for (int c = 0; c < total; c++) begin
            emif_ce_n = (c >= t.len);
            if (t.is_rd) emif_oe_n = (c >= t.len);
            else         emif_we_n = (c >= t.len);
            rd_valid = t.is_rd ? (c == vcyc) : ($urandom_range(0, 3) == 0);
            rd_data  = (t.is_rd && c == vcyc) ? t.rdata : DW'($urandom);
            @(posedge clk); #1;
        end
        emif_ce_n = 1'b1; emif_we_n = 1'b1; emif_oe_n = 1'b1; rd_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_doe"},   32'(emif_data_oe),  32'd0);
        chk({tag, "_dout"},  32'(emif_data_out), 32'd0);
        chk({tag, "_wren"},  32'(wr_en),         32'd0);
        chk({tag, "_waddr"}, 32'(wr_addr),       32'd0);
        chk({tag, "_wdata"}, 32'(wr_data),       32'd0);
        chk({tag, "_rdreq"}, 32'(rd_req),        32'd0);
        chk({tag, "_raddr"}, 32'(rd_addr),       32'd0);
        chk({tag, "_rdto"},  32'(rd_timeout),    32'd0);
    endtask

    vec_t vt[8];

    initial begin
        int k, erel, nwr, nrq, nto, ndrv, kk, nmin;
        bit found;
        txn_t t;

        vt[0] = mkv(mkt(1'b0, 8'h3C, 16'hA55A, 10, -1, 16'h0),    1, 0, 0, 0, 15, 32'h3C,   32'hA55A, -1);
        vt[1] = mkv(mkt(1'b1, 8'h11, 16'h0,    20,  3, 16'h1234), 0, 1, 0, 1,  9, 32'h1234, 32'h0,    25);
        vt[2] = mkv(mkt(1'b1, 8'h22, 16'h0,    25, -1, 16'h0),    0, 1, 1, 1, 20, 32'hFFFF, 32'h0,    30);
        vt[3] = mkv(mkt(1'b0, 8'h77, 16'h1111,  1, -1, 16'h0),    0, 0, 0, 0, -1, 32'h0,    32'h0,    -1);
        vt[4] = mkv(mkt(1'b1, 8'h33, 16'h0,     7,  8, 16'hCAFE), 0, 1, 0, 0, -1, 32'h0,    32'h0,    -1);
        vt[5] = mkv(mkt(1'b1, 8'h44, 16'h0,    25, 14, 16'hBEEF), 0, 1, 0, 1, 20, 32'hBEEF, 32'h0,    30);
        vt[6] = mkv(mkt(1'b1, 8'h66, 16'h0,     1,  0, 16'h5555), 0, 0, 0, 0, -1, 32'h0,    32'h0,    -1);
        vt[7] = mkv(mkt(1'b0, 8'h05, 16'h0F0F,  2, -1, 16'h0),    1, 0, 0, 0,  7, 32'h05,   32'h0F0F, -1);

        rst = 1'b1;
        emif_ce_n = 1'b1; emif_we_n = 1'b1; emif_oe_n = 1'b1;
        emif_addr = '0; emif_data_in = '0; rd_data = '0; rd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        for (int i = 0; i < 8; i++) begin
            act.delete();
            k = cyc;
            run_txn(vt[i].t);
            nwr = 0; nrq = 0; nto = 0; ndrv = 0;
            foreach (act[j]) begin
                if (act[j].kind == EV_WR)  nwr++;
                if (act[j].kind == EV_RQ)  nrq++;
                if (act[j].kind == EV_TO)  nto++;
                if (act[j].kind == EV_DRV) ndrv++;
            end
            chk($sformatf("v%0d_n_wr", i),  32'(nwr),  32'(vt[i].n_wr));
            chk($sformatf("v%0d_n_rq", i),  32'(nrq),  32'(vt[i].n_rq));
            chk($sformatf("v%0d_n_to", i),  32'(nto),  32'(vt[i].n_to));
            chk($sformatf("v%0d_n_drv", i), 32'(ndrv), 32'(vt[i].n_drv));
            foreach (act[j]) begin
                if (act[j].kind == EV_RQ) begin
                    chk($sformatf("v%0d_rq_cyc", i),  32'(act[j].cyc), 32'(k + LAT + 1));
                    chk($sformatf("v%0d_rq_addr", i), act[j].a,        32'(vt[i].t.addr));
                end
            end
            if (vt[i].key_off >= 0) begin
                kk = vt[i].t.is_rd ? EV_DRV : EV_WR;
                found = 1'b0;
                foreach (act[j]) begin
                    if (!found && act[j].kind == kk) begin
                        found = 1'b1;
                        chk($sformatf("v%0d_key_cyc", i), 32'(act[j].cyc), 32'(k + vt[i].key_off));
                        chk($sformatf("v%0d_key_a", i),   act[j].a,        vt[i].key_a);
                        chk($sformatf("v%0d_key_b", i),   act[j].b,        vt[i].key_b);
                    end
                end
                chk($sformatf("v%0d_key_found", i), 32'(found), 32'd1);
            end
            if (vt[i].rel_off >= 0) begin
                found = 1'b0;
                foreach (act[j]) begin
                    if (!found && act[j].kind == EV_REL) begin
                        found = 1'b1;
                        chk($sformatf("v%0d_rel_cyc", i), 32'(act[j].cyc), 32'(k + vt[i].rel_off));
                    end
                end
                chk($sformatf("v%0d_rel_found", i), 32'(found), 32'd1);
            end
        end

        // Reset while driving read data, with the strobes held low across release
        emif_addr = 8'h5A; rd_data = '0; rd_valid = 1'b0;
        emif_ce_n = 1'b0; emif_oe_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (emif_data_oe) begin found = 1'b1; break; end
        end
        chk("rstmid_wait_drive", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rstmid");
        erel = cyc;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        found = 1'b0;
        foreach (act[j]) begin
            if (!found && act[j].kind == EV_RQ && act[j].cyc > erel) begin
                found = 1'b1;
                chk("rstrel_rq_cyc",  32'(act[j].cyc), 32'(erel + LAT + 1));
                chk("rstrel_rq_addr", act[j].a,        32'h5A);
            end
        end
        chk("rstrel_rq_found", 32'(found), 32'd1);
        @(posedge clk); #1;
        emif_ce_n = 1'b1; emif_oe_n = 1'b1;
        repeat (30) begin @(posedge clk); #1; end

        act.delete();
        expq.delete();
        for (int n = 0; n < 40; n++) begin
            int jv, jd;
            t.is_rd = ($urandom_range(0, 1) == 1);
            t.addr  = AW'($urandom);
            t.data  = DW'($urandom);
            t.len   = int'($urandom_range(1, 30));
            t.vd    = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
            t.rdata = DW'($urandom);
            if (t.is_rd) begin
                jv = (t.vd >= 0) ? t.vd + 1 : BIG;
                jd = (jv < RT) ? jv : RT;
                if (t.len == jd) t.len++;
            end
            predict(t, cyc);
            run_txn(t);
        end
        repeat (5) @(negedge clk);
        chk("rand_event_count", 32'(act.size()), 32'(expq.size()));
        nmin = (act.size() < expq.size()) ? act.size() : expq.size();
        for (int i = 0; i < nmin; i++) begin
            chk($sformatf("rand_ev%0d_kind", i), 32'(act[i].kind), 32'(expq[i].kind));
            chk($sformatf("rand_ev%0d_cyc", i),  32'(act[i].cyc),  32'(expq[i].cyc));
            chk($sformatf("rand_ev%0d_a", i),    act[i].a,         expq[i].a);
            chk($sformatf("rand_ev%0d_b", i),    act[i].b,         expq[i].b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
